// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and the default
// frame timing constants used by detect_bit, the receiver and the transmitter.
package uart_pkg;

    localparam int CLKS_PER_BIT = 16;
    localparam int DATA_BITS    = 8;
    localparam int FIRST_SAMPLE = 12;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit-period timer: load sets the first interval, tick fires
// when the count reaches zero while enabled, then RELOAD is reloaded.
// Ports: clk, rst_n (sync, active low), load, load_val, en -> tick.
module uart_bit_timer #(
    parameter int WIDTH  = 4,
    parameter int RELOAD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    localparam logic [WIDTH-1:0] RLD = WIDTH'(RELOAD);

    logic [WIDTH-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= tick ? RLD : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame capture: after the startbit pulse, samples rxin at
// the bit centres, assembles data LSB-first and checks parity and stop.
// Ports: clk, rst_n (sync, active low), rxin, startbit -> data_out,
// data_valid (one-cycle strobe), parity_err, frame_err, busy.
module uart_rx_frame #(
    parameter int DATA_BITS    = uart_pkg::DATA_BITS,
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int FIRST_SAMPLE = uart_pkg::FIRST_SAMPLE,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxin,
    input  logic                 startbit,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int TMAX = (CLKS_PER_BIT > FIRST_SAMPLE) ?
                          CLKS_PER_BIT : FIRST_SAMPLE;
    localparam int CW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] FIRST_LOAD = CW'(FIRST_SAMPLE - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_BITS - 1);

    rx_state_t state_q, state_d;

    logic [DATA_BITS-1:0] shreg;
    logic [IW-1:0]        idx;
    logic                 par_flag;
    logic                 par_calc;
    logic                 tick;
    logic                 start;
    logic                 last_bit;
    logic                 take_data;
    logic                 take_par;
    logic                 take_stop;

    uart_bit_timer #(
        .WIDTH  (CW),
        .RELOAD (CLKS_PER_BIT - 1)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .load_val (FIRST_LOAD),
        .en       (state_q != IDLE),
        .tick     (tick)
    );

    assign last_bit = (idx == LAST_IDX);
    assign par_calc = (^shreg) ^ (PARITY_ODD != 0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // startbit is only honoured in IDLE, so pulses mid-frame or on the
    // stop tick leave the timer and bit index untouched.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        take_data = 1'b0;
        take_par  = 1'b0;
        take_stop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (startbit) begin
                    start   = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                take_data = tick;
                if (tick && last_bit) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                take_par = tick;
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                take_stop = tick;
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg      <= '0;
            idx        <= '0;
            par_flag   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (start) begin
                shreg    <= '0;
                idx      <= '0;
                par_flag <= 1'b0;
                busy     <= 1'b1;
            end
            // LSB arrives first, so shift in at the top.
            if (take_data) begin
                shreg <= {rxin, shreg[DATA_BITS-1:1]};
                idx   <= idx + 1'b1;
            end
            if (take_par) begin
                par_flag <= (rxin != par_calc);
            end
            if (take_stop) begin
                data_out   <= shreg;
                parity_err <= par_flag;
                frame_err  <= !rxin;
                data_valid <= 1'b1;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: three instances (even parity,
// no parity, odd parity) share the line; directed scenarios plus a random run.
module tb_uart_rx_frame;

    localparam int N = 2048;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } strobe_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxin;
    logic       startbit;
    logic [7:0] dout [3];
    logic       dv   [3];
    logic       pe   [3];
    logic       fe   [3];
    logic       bz   [3];

    int checks = 0;
    int errors = 0;

    // Schedule: index i is the value sampled at the i-th edge of a run.
    logic lvl  [N];
    logic sbv  [N];
    logic rstv [N];

    // Observed outputs: index s is the value visible just before edge s.
    logic       o_bz [3][N];
    logic       o_dv [3][N];
    logic       o_pe [3][N];
    logic       o_fe [3][N];
    logic [7:0] o_d  [3][N];

    strobe_t cap [3][$];
    strobe_t exp_q [$];

    always #5 clk = ~clk;

    uart_rx_frame #(
        .DATA_BITS(8), .CLKS_PER_BIT(16), .FIRST_SAMPLE(12),
        .PARITY_EN(1), .PARITY_ODD(0)
    ) u_even (
        .clk(clk), .rst_n(rst_n), .rxin(rxin), .startbit(startbit),
        .data_out(dout[0]), .data_valid(dv[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .busy(bz[0])
    );

    uart_rx_frame #(
        .DATA_BITS(8), .CLKS_PER_BIT(16), .FIRST_SAMPLE(12),
        .PARITY_EN(0), .PARITY_ODD(0)
    ) u_nopar (
        .clk(clk), .rst_n(rst_n), .rxin(rxin), .startbit(startbit),
        .data_out(dout[1]), .data_valid(dv[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .busy(bz[1])
    );

    uart_rx_frame #(
        .DATA_BITS(8), .CLKS_PER_BIT(16), .FIRST_SAMPLE(12),
        .PARITY_EN(1), .PARITY_ODD(1)
    ) u_odd (
        .clk(clk), .rst_n(rst_n), .rxin(rxin), .startbit(startbit),
        .data_out(dout[2]), .data_valid(dv[2]), .parity_err(pe[2]),
        .frame_err(fe[2]), .busy(bz[2])
    );

    // Line is random junk except exactly at the bit centres of frames.
    task automatic clear_sched();
        for (int i = 0; i < N; i++) begin
            lvl[i]  = 1'($urandom);
            sbv[i]  = 1'b0;
            rstv[i] = 1'b0;
        end
        for (int k = 0; k < 3; k++) cap[k].delete();
    endtask

    // Bit j after the start bit is centred FIRST_SAMPLE + 16*j after startbit.
    task automatic put_frame(input int t, input logic [7:0] d,
                             input logic pbit, input int pen,
                             input logic stop);
        sbv[t] = 1'b1;
        for (int j = 0; j < 8; j++) lvl[t + 12 + 16 * j] = d[j];
        if (pen != 0) lvl[t + 12 + 128] = pbit;
        lvl[t + 12 + 16 * (8 + pen)] = stop;
    endtask

    task automatic apply(input int i);
        rxin     = lvl[i];
        startbit = sbv[i];
        rst_n    = !rstv[i];
    endtask

    task automatic run(input int n);
        strobe_t e;
        apply(0);
        for (int s = 1; s < n; s++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                o_bz[k][s] = bz[k];
                o_dv[k][s] = dv[k];
                o_pe[k][s] = pe[k];
                o_fe[k][s] = fe[k];
                o_d[k][s]  = dout[k];
                if (dv[k] === 1'b1) begin
                    e.t  = s;
                    e.d  = dout[k];
                    e.pe = pe[k];
                    e.fe = fe[k];
                    cap[k].push_back(e);
                end
            end
            apply(s);
        end
    endtask

    // Frame-level reference: a startbit starts a frame only when no frame is
    // pending; the strobe follows the stop-centre edge; reset drops the frame.
    task automatic build_model(input int k, input int len);
        int         pen, podd, st, stop_t;
        bit         pend;
        logic [7:0] d;
        logic       pc;
        strobe_t    e;
        pen  = (k == 1) ? 0 : 1;
        podd = (k == 2) ? 1 : 0;
        exp_q.delete();
        pend   = 1'b0;
        st     = 0;
        stop_t = 0;
        for (int t = 0; t < len; t++) begin
            if (rstv[t]) begin
                pend = 1'b0;
            end else if (pend && t == stop_t) begin
                for (int j = 0; j < 8; j++) d[j] = lvl[st + 12 + 16 * j];
                pc   = (^d) ^ podd[0];
                e.t  = t + 1;
                e.d  = d;
                e.pe = (pen == 1) && (lvl[st + 140] != pc);
                e.fe = !lvl[t];
                if (t + 1 < len) exp_q.push_back(e);
                pend = 1'b0;
            end else if (!pend && sbv[t]) begin
                pend   = 1'b1;
                st     = t;
                stop_t = t + 12 + 16 * (8 + pen);
            end
        end
    endtask

    task automatic test_reset();
        clear_sched();
        for (int i = 0; i < 4; i++) rstv[i] = 1'b1;
        run(10);
        for (int k = 0; k < 3; k++) begin
            for (int s = 4; s <= 8; s += 4) begin
                checks++;
                if ({o_dv[k][s], o_pe[k][s], o_fe[k][s], o_bz[k][s],
                     o_d[k][s]} !== 12'h000) begin
                    errors++;
                    $display("FAIL reset_u%0d@%0d: got dv=%b pe=%b fe=%b busy=%b d=%h, expected all 0",
                             k, s, o_dv[k][s], o_pe[k][s], o_fe[k][s],
                             o_bz[k][s], o_d[k][s]);
                end
            end
        end
    endtask

    task automatic test_defaults();
        int t;
        int bad;
        t = 20;
        clear_sched();
        put_frame(t, 8'hA5, 1'b0, 1, 1'b1);
        run(t + 200);
        checks++;
        if (cap[0].size() != 1) begin
            errors++;
            $display("FAIL defaults_count: got %0d strobes, expected 1",
                     cap[0].size());
        end else begin
            checks++;
            if (cap[0][0].t != t + 157 || cap[0][0].d !== 8'hA5 ||
                {cap[0][0].pe, cap[0][0].fe} !== 2'b00) begin
                errors++;
                $display("FAIL defaults_strobe: got t=%0d d=%h pe=%b fe=%b, expected t=%0d d=a5 pe=0 fe=0",
                         cap[0][0].t, cap[0][0].d, cap[0][0].pe,
                         cap[0][0].fe, t + 157);
            end
        end
        bad = 0;
        for (int s = t + 1; s <= t + 156; s++) if (o_bz[0][s] !== 1'b1) bad++;
        if (o_bz[0][t] !== 1'b0) bad++;
        if (o_bz[0][t + 157] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL defaults_busy: got %0d wrong busy cycles, expected 0",
                     bad);
        end
    endtask

    task automatic test_parity_error();
        int t;
        t = 15;
        clear_sched();
        put_frame(t, 8'hA5, 1'b1, 1, 1'b1);
        run(t + 200);
        checks++;
        if (cap[0].size() != 1) begin
            errors++;
            $display("FAIL parity_count: got %0d strobes, expected 1",
                     cap[0].size());
        end else begin
            checks++;
            if (cap[0][0].t != t + 157 || cap[0][0].d !== 8'hA5 ||
                {cap[0][0].pe, cap[0][0].fe} !== 2'b10) begin
                errors++;
                $display("FAIL parity_strobe: got t=%0d d=%h pe=%b fe=%b, expected t=%0d d=a5 pe=1 fe=0",
                         cap[0][0].t, cap[0][0].d, cap[0][0].pe,
                         cap[0][0].fe, t + 157);
            end
        end
    endtask

    task automatic test_no_parity();
        int t;
        t = 12;
        clear_sched();
        put_frame(t, 8'h3C, 1'b0, 0, 1'b0);
        run(t + 200);
        checks++;
        if (cap[1].size() != 1) begin
            errors++;
            $display("FAIL nopar_count: got %0d strobes, expected 1",
                     cap[1].size());
        end else begin
            checks++;
            if (cap[1][0].t != t + 141 || cap[1][0].d !== 8'h3C ||
                {cap[1][0].pe, cap[1][0].fe} !== 2'b01) begin
                errors++;
                $display("FAIL nopar_strobe: got t=%0d d=%h pe=%b fe=%b, expected t=%0d d=3c pe=0 fe=1",
                         cap[1][0].t, cap[1][0].d, cap[1][0].pe,
                         cap[1][0].fe, t + 141);
            end
        end
    endtask

    task automatic test_extra_start();
        int t;
        t = 18;
        clear_sched();
        put_frame(t, 8'h5A, 1'b0, 1, 1'b1);
        sbv[t + 50]  = 1'b1;
        sbv[t + 156] = 1'b1;
        run(t + 340);
        checks++;
        if (cap[0].size() != 1) begin
            errors++;
            $display("FAIL extra_count: got %0d strobes, expected 1",
                     cap[0].size());
        end else begin
            checks++;
            if (cap[0][0].t != t + 157 || cap[0][0].d !== 8'h5A ||
                {cap[0][0].pe, cap[0][0].fe} !== 2'b00) begin
                errors++;
                $display("FAIL extra_strobe: got t=%0d d=%h pe=%b fe=%b, expected t=%0d d=5a pe=0 fe=0",
                         cap[0][0].t, cap[0][0].d, cap[0][0].pe,
                         cap[0][0].fe, t + 157);
            end
        end
    endtask

    task automatic test_back_to_back();
        int         t;
        logic [7:0] b1;
        logic [7:0] want [2];
        t  = 14;
        b1 = 8'($urandom);
        want[0] = b1;
        want[1] = 8'hFF;
        clear_sched();
        put_frame(t, b1, ~(^b1), 1, 1'b1);
        put_frame(t + 157, 8'hFF, 1'b1, 1, 1'b1);
        run(t + 360);
        checks++;
        if (cap[2].size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d strobes, expected 2",
                     cap[2].size());
        end else begin
            for (int f = 0; f < 2; f++) begin
                checks++;
                if (cap[2][f].t != t + 157 * (f + 1) ||
                    cap[2][f].d !== want[f] ||
                    {cap[2][f].pe, cap[2][f].fe} !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_strobe%0d: got t=%0d d=%h pe=%b fe=%b, expected t=%0d d=%h pe=0 fe=0",
                             f, cap[2][f].t, cap[2][f].d, cap[2][f].pe,
                             cap[2][f].fe, t + 157 * (f + 1), want[f]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int         t;
        logic [7:0] b;
        t = 16;
        b = 8'($urandom);
        clear_sched();
        put_frame(t, b, ^b, 1, 1'b1);
        rstv[t + 60] = 1'b1;
        put_frame(t + 100, 8'h81, 1'b0, 1, 1'b1);
        run(t + 300);
        for (int s = t + 61; s <= t + 62; s++) begin
            checks++;
            if ({o_dv[0][s], o_pe[0][s], o_fe[0][s], o_bz[0][s],
                 o_d[0][s]} !== 12'h000) begin
                errors++;
                $display("FAIL rstmid_out@%0d: got dv=%b pe=%b fe=%b busy=%b d=%h, expected all 0",
                         s - t, o_dv[0][s], o_pe[0][s], o_fe[0][s],
                         o_bz[0][s], o_d[0][s]);
            end
        end
        checks++;
        if (cap[0].size() != 1) begin
            errors++;
            $display("FAIL rstmid_count: got %0d strobes, expected 1",
                     cap[0].size());
        end else begin
            checks++;
            if (cap[0][0].t != t + 257 || cap[0][0].d !== 8'h81 ||
                {cap[0][0].pe, cap[0][0].fe} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_strobe: got t=%0d d=%h pe=%b fe=%b, expected t=%0d d=81 pe=0 fe=0",
                         cap[0][0].t, cap[0][0].d, cap[0][0].pe,
                         cap[0][0].fe, t + 257);
            end
        end
    endtask

    task automatic test_random();
        int         t;
        int         len;
        logic [7:0] b;
        clear_sched();
        t = 10;
        for (int f = 0; f < 6; f++) begin
            b = 8'($urandom);
            put_frame(t, b, 1'($urandom), 1, ($urandom_range(0, 3) != 0));
            sbv[t + $urandom_range(1, 160)] = 1'b1;
            t += 157 + $urandom_range(0, 6);
        end
        rstv[$urandom_range(300, 600)] = 1'b1;
        len = t + 250;
        run(len);
        for (int k = 0; k < 3; k++) begin
            build_model(k, len);
            checks++;
            if (cap[k].size() != exp_q.size()) begin
                errors++;
                $display("FAIL random_u%0d_count: got %0d strobes, expected %0d",
                         k, cap[k].size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (cap[k][i].t != exp_q[i].t ||
                        cap[k][i].d !== exp_q[i].d ||
                        cap[k][i].pe !== exp_q[i].pe ||
                        cap[k][i].fe !== exp_q[i].fe) begin
                        errors++;
                        $display("FAIL random_u%0d[%0d]: got t=%0d d=%h pe=%b fe=%b, expected t=%0d d=%h pe=%b fe=%b",
                                 k, i, cap[k][i].t, cap[k][i].d,
                                 cap[k][i].pe, cap[k][i].fe, exp_q[i].t,
                                 exp_q[i].d, exp_q[i].pe, exp_q[i].fe);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rxin     = 1'b1;
        startbit = 1'b0;
        test_reset();
        test_defaults();
        test_parity_error();
        test_no_parity();
        test_extra_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Receive-frame capture stage that sits directly downstream of the start-bit detector (detect_bit).
- Armed by the detector's one-cycle `startbit` pulse.
- Times the remaining bit periods from the oversampling clock and samples `rxin` at the bit centres.
- Assembles DATA_BITS data bits LSB-first, checks optional parity and the stop bit.
- Presents the byte with a one-cycle valid strobe and error flags to the receive buffer.

Parameters:
- DATA_BITS, 8: number of data bits per frame (5..8).
- CLKS_PER_BIT, 16: clk cycles per UART bit period (oversampling ratio).
- FIRST_SAMPLE, 12: cycles from the `startbit` pulse to the data-bit-0 centre sample. The detector fires 12 cycles after the first low sample: 12 + 16 - 8 - 8 = 12.
- PARITY_EN, 1: 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock, rising edge; same clock as detect_bit.
- rst_n  in  1  synchronous active-low reset.
- rxin  in  1  serial line, already synchronised; idle high.
- startbit  in  1  one-cycle pulse from detect_bit; start bit confirmed.
- data_out  out  DATA_BITS  received byte; holds its value until the next frame completes.
- data_valid  out  1  one-cycle strobe; data_out and the error flags are valid.
- parity_err  out  1  parity mismatch on the frame just strobed.
- frame_err  out  1  stop bit sampled low on the frame just strobed.
- busy  out  1  high from the cycle after startbit is accepted until the stop sample.

Behaviour:
- Reset:
  - One clk and reset are used. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - On reset: state = IDLE; data_out = 0; data_valid = 0; parity_err = 0; frame_err = 0; busy = 0; counters = 0.
  - Reset asserted mid-frame abandons the frame. No strobe is produced.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - On `startbit` = 1, load the bit timer with FIRST_SAMPLE - 1, clear the bit index and shift register, and go to DATA.
  - `busy` = 1 from the next cycle.
- Bit timer:
  - Decrements every cycle.
  - Reaching 0 is a sample tick, then reloads CLKS_PER_BIT - 1.
  - With startbit at cycle T: data bit k is sampled at T + FIRST_SAMPLE + k*CLKS_PER_BIT.
- DATA:
  - Each tick shifts `rxin` into the MSB of the shift register (LSB-first arrival).
  - After DATA_BITS ticks, go to PARITY if PARITY_EN = 1, else to STOP.
- PARITY:
  - On the tick, parity_calc = XOR of the data bits, XOR'd with PARITY_ODD.
  - Mismatch = (rxin != parity_calc); latch it into an internal flag.
  - Go to STOP.
- STOP, on the tick:
  - data_out <= shift register; parity_err <= latched flag; frame_err <= !rxin; data_valid <= 1 (visible the cycle after the stop tick).
  - busy <= 0; go to IDLE.
- data_valid is high exactly one cycle, including when frame_err = 1. The byte is still delivered; the consumer decides whether to discard it.
- parity_err and frame_err:
  - Change only with a data_valid strobe and hold until the next one.
  - parity_err is always 0 when PARITY_EN = 0.
- `startbit` while busy = 1 is ignored. No restart and no counter disturbance.
- `startbit` in the same cycle as the stop tick is ignored.
- `startbit` in the data_valid cycle is accepted; back-to-back frames are supported.
- No handshake back-pressure. The consumer must take data_out within one frame time.

Decomposition:
- Package uart_pkg holds:
  - the state encoding enum (IDLE, DATA, PARITY, STOP);
  - the default constants CLKS_PER_BIT, DATA_BITS, FIRST_SAMPLE, shared with detect_bit and the transmitter.
- Sub-module uart_bit_timer (load value, enable, tick output) is natural. It is reusable by the transmitter baud generator.
- Shift register, bit index and FSM stay in uart_rx_frame.

Test Plan:
- Defaults. Drive 0xA5 LSB-first plus parity 0 (even) and stop 1 at 16 cycles/bit; startbit at T.
  - data_valid at T+157 only; data_out = 0xA5; parity_err = 0; frame_err = 0.
  - busy high T+1..T+156.
- Same frame with the parity bit driven 1 -> data_out = 0xA5, parity_err = 1, frame_err = 0 at T+157.
- PARITY_EN = 0, byte 0x3C, stop bit driven 0 -> data_valid at T+141; data_out = 0x3C; frame_err = 1; parity_err = 0.
- Extra startbit pulses at T+50 and T+156 during frame 0x5A -> single strobe at T+157 with data_out = 0x5A; timing unchanged.
- Back-to-back: second startbit at T+157, byte 0xFF, odd parity (PARITY_ODD = 1, parity bit 1) -> second strobe at T+314; data_out = 0xFF; no errors.
- rst_n low at T+60 for one cycle mid-frame:
  - all outputs 0 at T+61, state IDLE, no strobe;
  - a new frame 0x81 then completes normally.
